// File: rtl/key_pos_ctrl_if.sv
// Key-level inputs and object position/colour outputs between the debouncers,
// key_pos_ctrl and the VGA pixel generator.
interface key_pos_ctrl_if;
  localparam int unsigned POS_W = 10;
  localparam int unsigned COL_W = 3;

  logic             key_up;
  logic             key_down;
  logic             key_left;
  logic             key_right;
  logic             key_mid;
  logic [POS_W-1:0] pos_x;
  logic [POS_W-1:0] pos_y;
  logic [COL_W-1:0] color;
  logic             move_pulse;

  // master drives the keys and consumes the object state
  modport master (
    output key_up, key_down, key_left, key_right, key_mid,
    input  pos_x, pos_y, color, move_pulse
  );

  modport slave (
    input  key_up, key_down, key_left, key_right, key_mid,
    output pos_x, pos_y, color, move_pulse
  );
endinterface

// File: rtl/key_pos_ctrl.sv
// Turns five active-low debounced keys into a saturating on-screen position
// with press/hold auto-repeat, plus a colour index cycled by the centre key.
module key_pos_ctrl #(
  parameter int unsigned X_MAX       = 639,
  parameter int unsigned Y_MAX       = 479,
  parameter int unsigned X_INIT      = 320,
  parameter int unsigned Y_INIT      = 240,
  parameter int unsigned STEP        = 8,
  parameter int unsigned REPEAT_DLY  = 25000000,
  parameter int unsigned REPEAT_RATE = 5000000
) (
  input  logic           CLK,
  input  logic           RESET,
  key_pos_ctrl_if.slave  bus
);

  localparam int unsigned POS_W = 10;
  localparam int unsigned EXT_W = 11;
  localparam int unsigned CNT_W = 25;
  localparam int unsigned COL_W = 3;
  localparam int unsigned KEY_W = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  logic [KEY_W-1:0] key_raw;
  logic [KEY_W-1:0] sync1;
  logic [KEY_W-1:0] sync2;
  logic             mid_prev;

  state_t           state;
  dir_t             dir;
  logic [CNT_W-1:0] cnt;

  logic [POS_W-1:0] pos_x;
  logic [POS_W-1:0] pos_y;
  logic [COL_W-1:0] color;
  logic             move_pulse;

  logic [3:0]       press;
  logic             any_press;
  logic             held;
  logic             step;
  dir_t             pick_dir;
  dir_t             step_dir;

  // bit order: up, down, left, right, mid
  assign key_raw = {bus.key_up, bus.key_down, bus.key_left, bus.key_right, bus.key_mid};
  assign press   = ~sync2[4:1];

  // Priority pick, held test on the latched direction, and step decision
  always_comb begin
    pick_dir  = DIR_RIGHT;
    any_press = |press;
    held      = 1'b0;
    step      = 1'b0;
    if (press[3])      pick_dir = DIR_UP;
    else if (press[2]) pick_dir = DIR_DOWN;
    else if (press[1]) pick_dir = DIR_LEFT;

    case (dir)
      DIR_UP:    held = press[3];
      DIR_DOWN:  held = press[2];
      DIR_LEFT:  held = press[1];
      DIR_RIGHT: held = press[0];
      default:   held = 1'b0;
    endcase

    step_dir = (state == IDLE) ? pick_dir : dir;

    case (state)
      IDLE:    step = any_press;
      HOLD:    step = held && (cnt == CNT_W'(REPEAT_DLY - 1));
      REPEAT:  step = held && (cnt == CNT_W'(REPEAT_RATE - 1));
      default: step = 1'b0;
    endcase
  end

  function automatic logic [POS_W-1:0] sat_dec(input logic [POS_W-1:0] p);
    logic [EXT_W-1:0] e;
    e = EXT_W'(p);
    if (e < EXT_W'(STEP)) sat_dec = '0;
    else                  sat_dec = POS_W'(e - EXT_W'(STEP));
  endfunction

  function automatic logic [POS_W-1:0] sat_inc(input logic [POS_W-1:0] p,
                                               input logic [EXT_W-1:0] lim);
    logic [EXT_W-1:0] e;
    e = EXT_W'(p) + EXT_W'(STEP);
    if (e > lim) sat_inc = POS_W'(lim);
    else         sat_inc = POS_W'(e);
  endfunction

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync1      <= '1;
      sync2      <= '1;
      mid_prev   <= 1'b1;
      state      <= IDLE;
      dir        <= DIR_UP;
      cnt        <= '0;
      pos_x      <= POS_W'(X_INIT);
      pos_y      <= POS_W'(Y_INIT);
      color      <= '0;
      move_pulse <= 1'b0;
    end else begin
      sync1    <= key_raw;
      sync2    <= sync1;
      mid_prev <= sync2[0];

      // colour advances on the press edge only, never on hold
      if (mid_prev && !sync2[0]) color <= color + COL_W'(1);

      move_pulse <= step;
      if (step) begin
        case (step_dir)
          DIR_UP:    pos_y <= sat_dec(pos_y);
          DIR_DOWN:  pos_y <= sat_inc(pos_y, EXT_W'(Y_MAX));
          DIR_LEFT:  pos_x <= sat_dec(pos_x);
          DIR_RIGHT: pos_x <= sat_inc(pos_x, EXT_W'(X_MAX));
          default:   pos_x <= pos_x;
        endcase
      end

      // Releasing the latched key always drops to IDLE, even if others are held
      case (state)
        IDLE: begin
          if (any_press) begin
            dir   <= pick_dir;
            cnt   <= '0;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (!held) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (cnt == CNT_W'(REPEAT_DLY - 1)) begin
            cnt   <= '0;
            state <= REPEAT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        REPEAT: begin
          if (!held) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (cnt == CNT_W'(REPEAT_RATE - 1)) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.pos_x      = pos_x;
  assign bus.pos_y      = pos_y;
  assign bus.color      = color;
  assign bus.move_pulse = move_pulse;

endmodule

// File: tb/tb_key_pos_ctrl.sv
// Bench for key_pos_ctrl: two instances (centre start and near-edge start) share
// one key stimulus and are checked every cycle against a hold-time model.
module tb_key_pos_ctrl;

  localparam int STEP = 8;
  localparam int DLY  = 10;
  localparam int RATE = 4;
  localparam int XMAX = 639;
  localparam int YMAX = 479;

  int xinit [2] = '{320, 636};
  int yinit [2] = '{240, 5};

  logic CLK   = 1'b0;
  logic RESET = 1'b1;
  logic k_up = 1'b1, k_down = 1'b1, k_left = 1'b1, k_right = 1'b1, k_mid = 1'b1;

  always #5 CLK = ~CLK;

  key_pos_ctrl_if bus0 ();
  key_pos_ctrl_if bus1 ();

  assign bus0.key_up = k_up;  assign bus0.key_down = k_down;  assign bus0.key_left = k_left;
  assign bus0.key_right = k_right;  assign bus0.key_mid = k_mid;
  assign bus1.key_up = k_up;  assign bus1.key_down = k_down;  assign bus1.key_left = k_left;
  assign bus1.key_right = k_right;  assign bus1.key_mid = k_mid;

  key_pos_ctrl #(.X_MAX(639), .Y_MAX(479), .X_INIT(320), .Y_INIT(240), .STEP(8),
                 .REPEAT_DLY(10), .REPEAT_RATE(4))
    u_dut0 (.CLK(CLK), .RESET(RESET), .bus(bus0.slave));

  key_pos_ctrl #(.X_MAX(639), .Y_MAX(479), .X_INIT(636), .Y_INIT(5), .STEP(8),
                 .REPEAT_DLY(10), .REPEAT_RATE(4))
    u_dut1 (.CLK(CLK), .RESET(RESET), .bus(bus1.slave));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: keys are seen two edges late; steps happen at hold offsets 0, DLY, DLY+k*RATE
  int   mx [2], my [2], mcol [2], mdir [2], mt [2];
  bit   mpulse [2];
  logic [4:0] h1, h2;
  logic mprev;

  always @(posedge CLK or negedge RESET) begin
    logic [4:0] cur;
    logic [3:0] pr;
    bit fall, st;
    if (!RESET) begin
      h1 = '1; h2 = '1; mprev = 1'b1;
      for (int i = 0; i < 2; i++) begin
        mx[i] = xinit[i]; my[i] = yinit[i]; mcol[i] = 0;
        mpulse[i] = 1'b0; mdir[i] = -1; mt[i] = 0;
      end
    end else begin
      cur = h2;
      h2  = h1;
      h1  = {k_up, k_down, k_left, k_right, k_mid};
      fall  = mprev && !cur[0];
      mprev = cur[0];
      pr = ~cur[4:1];
      for (int i = 0; i < 2; i++) begin
        if (fall) mcol[i] = (mcol[i] + 1) % 8;
        st = 1'b0;
        if (mdir[i] < 0) begin
          if (pr != 4'd0) begin
            mdir[i] = pr[3] ? 0 : pr[2] ? 1 : pr[1] ? 2 : 3;
            mt[i] = 0;
            st = 1'b1;
          end
        end else if (pr[3 - mdir[i]]) begin
          mt[i]++;
          if (mt[i] == DLY || (mt[i] > DLY && (mt[i] - DLY) % RATE == 0)) st = 1'b1;
        end else begin
          mdir[i] = -1;
        end
        mpulse[i] = st;
        if (st) begin
          case (mdir[i])
            0: my[i] = (my[i] < STEP) ? 0 : my[i] - STEP;
            1: my[i] = (my[i] + STEP > YMAX) ? YMAX : my[i] + STEP;
            2: mx[i] = (mx[i] < STEP) ? 0 : mx[i] - STEP;
            default: mx[i] = (mx[i] + STEP > XMAX) ? XMAX : mx[i] + STEP;
          endcase
        end
      end
    end
  end

  bit run_cmp = 1'b0;
  int pc0 = 0, pc1 = 0;

  always @(negedge CLK) begin
    if (run_cmp) begin
      check("pos_x0", int'(bus0.pos_x), mx[0]);
      check("pos_y0", int'(bus0.pos_y), my[0]);
      check("color0", int'(bus0.color), mcol[0]);
      check("pulse0", int'(bus0.move_pulse), int'(mpulse[0]));
      check("pos_x1", int'(bus1.pos_x), mx[1]);
      check("pos_y1", int'(bus1.pos_y), my[1]);
      check("color1", int'(bus1.color), mcol[1]);
      check("pulse1", int'(bus1.move_pulse), int'(mpulse[1]));
      if (bus0.move_pulse) pc0++;
      if (bus1.move_pulse) pc1++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic tap_right(); k_right = 1'b0; cycles(3); k_right = 1'b1; cycles(6); endtask
  task automatic tap_left();  k_left  = 1'b0; cycles(3); k_left  = 1'b1; cycles(6); endtask
  task automatic tap_up();    k_up    = 1'b0; cycles(3); k_up    = 1'b1; cycles(6); endtask

  int p0, p1;

  initial begin
    #2 RESET = 1'b0;
    repeat (3) @(posedge CLK);
    #3 RESET = 1'b1;
    run_cmp = 1'b1;
    cycles(2);

    // reset state and single tap
    check("rst_x", int'(bus0.pos_x), 320);
    check("rst_y", int'(bus0.pos_y), 240);
    check("rst_color", int'(bus0.color), 0);
    check("rst_pulse", int'(bus0.move_pulse), 0);
    p0 = pc0;
    k_right = 1'b0;
    cycles(3);
    check("tap_x", int'(bus0.pos_x), 328);
    check("tap_pulse", int'(bus0.move_pulse), 1);
    k_right = 1'b1;
    cycles(1);
    check("tap_pulse_end", int'(bus0.move_pulse), 0);
    cycles(6);
    check("tap_x_hold", int'(bus0.pos_x), 328);
    check("tap_y", int'(bus0.pos_y), 240);
    check("tap_npulse", pc0 - p0, 1);
    check("sat_x1", int'(bus1.pos_x), 639);

    // auto-repeat: steps at offsets 0,10,14,18,22,26
    p0 = pc0;
    k_down = 1'b0;
    cycles(30);
    k_down = 1'b1;
    cycles(10);
    check("rep_y", int'(bus0.pos_y), 288);
    check("rep_npulse", pc0 - p0, 6);
    check("rep_y1", int'(bus1.pos_y), 53);

    // saturation at the right edge still pulses
    p1 = pc1;
    tap_right();
    check("sat_x1_again", int'(bus1.pos_x), 639);
    check("sat_npulse", pc1 - p1, 1);
    repeat (82) tap_left();
    check("sat_x0_zero", int'(bus0.pos_x), 0);
    check("sat_x1_zero", int'(bus1.pos_x), 0);
    repeat (8) tap_up();
    check("sat_y1_zero", int'(bus1.pos_y), 0);
    check("sat_y0", int'(bus0.pos_y), 224);

    // priority and handover
    repeat (5) tap_right();
    k_up = 1'b0; k_left = 1'b0;
    cycles(3);
    check("prio_y", int'(bus0.pos_y), 216);
    check("prio_x", int'(bus0.pos_x), 40);
    k_up = 1'b1;
    cycles(3);
    check("hand_idle_x", int'(bus0.pos_x), 40);
    check("hand_idle_pulse", int'(bus0.move_pulse), 0);
    cycles(1);
    check("hand_x", int'(bus0.pos_x), 32);
    check("hand_pulse", int'(bus0.move_pulse), 1);
    k_left = 1'b1;
    cycles(8);

    // colour wrap and no auto-repeat on hold
    for (int i = 1; i <= 9; i++) begin
      k_mid = 1'b0; cycles(2);
      k_mid = 1'b1; cycles(3);
      check("color_tap", int'(bus0.color), i % 8);
    end
    k_mid = 1'b0; cycles(50);
    k_mid = 1'b1; cycles(5);
    check("color_hold", int'(bus0.color), 2);

    // asynchronous reset while repeating
    k_right = 1'b0;
    cycles(16);
    #2 RESET = 1'b0;
    #1;
    check("mid_rst_x", int'(bus0.pos_x), 320);
    check("mid_rst_y", int'(bus0.pos_y), 240);
    check("mid_rst_color", int'(bus0.color), 0);
    check("mid_rst_x1", int'(bus1.pos_x), 636);
    @(posedge CLK);
    #3 RESET = 1'b1;
    cycles(2);
    check("post_rst_x", int'(bus0.pos_x), 320);
    check("post_rst_pulse", int'(bus0.move_pulse), 0);
    cycles(1);
    check("post_rst_step_x", int'(bus0.pos_x), 328);
    check("post_rst_step_pulse", int'(bus0.move_pulse), 1);
    k_right = 1'b1;
    cycles(8);

    // randomized key patterns with occasional mid-cycle resets
    repeat (200) begin
      if ($urandom_range(0, 3) == 0) begin
        {k_up, k_down, k_left, k_right} = 4'hf;
      end else begin
        k_up    = ($urandom_range(0, 2) != 0);
        k_down  = ($urandom_range(0, 2) != 0);
        k_left  = ($urandom_range(0, 2) != 0);
        k_right = ($urandom_range(0, 2) != 0);
      end
      k_mid = ($urandom_range(0, 1) != 0);
      if ($urandom_range(0, 39) == 0) begin
        #2 RESET = 1'b0;
        @(posedge CLK);
        #3 RESET = 1'b1;
      end
      cycles($urandom_range(1, 30));
    end
    {k_up, k_down, k_left, k_right, k_mid} = 5'h1f;
    cycles(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_pos_ctrl.md
# key_pos_ctrl

Converts the five debounced, active-low key levels into position and colour state for the on-screen VGA object. It sits directly downstream of the key debouncers and upstream of the VGA pixel generator, which reads `pos_x`, `pos_y` and `color` every frame. Each press of a direction key moves the object one step. Holding the key auto-repeats the step. The centre key cycles the object colour. All arithmetic saturates at the screen bounds.

## Interface
- `X_MAX`, 639: largest legal `pos_x`.
- `Y_MAX`, 479: largest legal `pos_y`.
- `X_INIT`, 320: reset value of `pos_x`.
- `Y_INIT`, 240: reset value of `pos_y`.
- `STEP`, 8: pixels moved per step event; 1..63.
- `REPEAT_DLY`, 25000000: hold cycles before the first auto-repeat; ≥2.
- `REPEAT_RATE`, 5000000: cycles between later auto-repeats; ≥2.
- `CLK`  in  1  system clock; one clock domain only.
- `RESET`  in  1  asynchronous, active-low reset.
- `key_up`, `key_down`, `key_left`, `key_right`, `key_mid`  in  1 each  debounced key levels; 0 = pressed. They are asynchronous to `CLK`.
- `pos_x`  out  10  object X coordinate.
- `pos_y`  out  10  object Y coordinate.
- `color`  out  3  object colour index.
- `move_pulse`  out  1  one-cycle strobe on every step event.

## Operation
- **Synchronizer.** Each key passes through a 2-flop synchronizer. The flops reset to 1 (released). Everything below uses the synchronized levels only.
- **Direction priority.** When several direction keys are pressed at once, priority is up > down > left > right.
- **State machine:** IDLE, HOLD, REPEAT. A 25-bit counter `cnt` and a latched direction `dir` support it.
  - IDLE: if any direction key is pressed, pick the highest-priority one. Latch it into `dir`, issue a step, clear `cnt`, go to HOLD. Otherwise stay in IDLE.
  - HOLD: if key `dir` is released, go to IDLE with no step. Otherwise increment `cnt`. When `cnt == REPEAT_DLY-1`, issue a step, clear `cnt` and go to REPEAT.
  - REPEAT: if key `dir` is released, go to IDLE. Otherwise increment `cnt`. When `cnt == REPEAT_RATE-1`, issue a step and clear `cnt`.
  - Releasing `dir` while another direction key is still held always goes through IDLE. The other key is then picked up on the next cycle as a fresh press (immediate step).
  - Presses of other direction keys while in HOLD or REPEAT are ignored.
- **Step arithmetic.** Computed in 11 bits, saturating.
  - Up: `pos_y <= (pos_y < STEP) ? 0 : pos_y-STEP`.
  - Down: `pos_y <= (pos_y+STEP > Y_MAX) ? Y_MAX : pos_y+STEP`.
  - Left and right apply the same rule to `pos_x`, bounded by 0 and `X_MAX`.
  - `move_pulse` is 1 for exactly the cycle in which the step is registered, including when saturation leaves the position unchanged.
- **Centre key.** A falling edge of synchronized `key_mid` increments `color` modulo 8 (7 wraps to 0). It has no auto-repeat. It works independently of the direction state machine, and colour and position may update in the same cycle.
- **Reset values.** `pos_x = X_INIT`, `pos_y = Y_INIT`, `color = 0`, `move_pulse = 0`, state = IDLE, `cnt = 0`, synchronizers = 1.
  - Reset asserted mid-hold forces these values immediately.
  - After reset is released while a key is still held, that key counts as a new press: step after synchronizer latency.

## Timing
- **Input to step latency.** A key falls before edge N. Edges N and N+1 fill the synchronizer. At edge N+2, the new `pos_x`/`pos_y` and `move_pulse = 1` are registered. `move_pulse` returns to 0 at edge N+3 unless another step occurs.
- **Release latency.** A key released before edge N is seen by the state machine at edge N+2 (transition to IDLE). No step is issued on or after that edge.
- **Colour latency.** `color` updates at edge N+2 after a `key_mid` falling input.
- **Hold step timing.** For a continuous hold, steps occur at cycle offsets 0, `REPEAT_DLY`, `REPEAT_DLY + k·REPEAT_RATE`, measured from the first step.
- All outputs are registered. None are combinational from the inputs.

## Test plan
1. **Reset and single tap.** Parameters `STEP=8`, `REPEAT_DLY=10`, `REPEAT_RATE=4`. Apply reset, then press `key_right` for 3 cycles. Required: `pos_x` 320 → 328 exactly once, with a single-cycle `move_pulse` 2 edges after the press; `pos_y` stays 240.
2. **Auto-repeat.** Same parameters. Hold `key_down` for 30 cycles. Required: steps at offsets 0, 10, 14, 18, 22, 26, giving `pos_y` 240 → 288. No steps after release + 2 cycles.
3. **Saturation.** Reset with `X_INIT=636` and `STEP=8`, then tap right. Required: `pos_x = 639` with `move_pulse = 1`. Tap right again: `pos_x` stays 639 and `move_pulse` still pulses. Tap left repeatedly from `pos_x = 5`: `pos_x` reaches 0 and never wraps.
4. **Priority and handover.** Press up and left in the same cycle. Required: only `pos_y` changes (−8). Release up while left is held: IDLE for one cycle, then an immediate left step (`pos_x` −8).
5. **Colour wrap.** Apply 9 taps of `key_mid`. Required: `color` runs 1, 2, …, 7, 0, 1. Holding `key_mid` for 50 cycles gives a single increment.
6. **Reset mid-hold.** Hold right in REPEAT state and assert `RESET` asynchronously between clock edges. Required: outputs return to 320/240/0 immediately. After release with the key still held, one step occurs at edge 3 after release.
